// File: rtl/mips_data_mem_if.sv
// Load/store port between the single-cycle MIPS core (master) and its data memory (slave).
interface mips_data_mem_if;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  modport master (output mem_read, mem_write, addr, write_data, input read_data);
  modport slave  (input mem_read, mem_write, addr, write_data, output read_data);
endinterface

// File: rtl/mips_data_mem.sv
// Zero-wait-state data memory: word RAM plus an MMIO page (GPIO, cycle counter, sticky status).
// Reads are combinational; writes, counter and status update on the rising edge of clk.
module mips_data_mem #(
  parameter int          ADDR_WIDTH = 8,
  parameter int          GPIO_WIDTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_data_mem_if.slave        bus,
  output logic [GPIO_WIDTH-1:0] gpio_out,
  output logic                  err
);

  localparam int          DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [31:0] RAM_BYTES = 32'(4 * DEPTH);
  localparam logic [31:0] GPIO_ADDR = MMIO_BASE;
  localparam logic [31:0] CYC_ADDR  = MMIO_BASE + 32'd4;
  localparam logic [31:0] STAT_ADDR = MMIO_BASE + 32'd8;

  logic [31:0] ram [DEPTH];
  logic [31:0] cyc_cnt;
  logic [1:0]  status;

  logic [31:0] addr_w;
  logic        misal, hit_ram, hit_gpio, hit_cyc, hit_stat, mapped, access;
  logic        wr_ok, rd_ok;
  logic [1:0]  stat_set, stat_clr;
  logic [ADDR_WIDTH-1:0] widx;

  // Mapping is judged on the word address so a misaligned hit on a real
  // location raises only the misaligned bit, not the unmapped one.
  assign addr_w   = {bus.addr[31:2], 2'b00};
  assign misal    = (bus.addr[1:0] != 2'b00);
  assign hit_ram  = (addr_w < RAM_BYTES);
  assign hit_gpio = (addr_w == GPIO_ADDR);
  assign hit_cyc  = (addr_w == CYC_ADDR);
  assign hit_stat = (addr_w == STAT_ADDR);
  assign mapped   = hit_ram | hit_gpio | hit_cyc | hit_stat;
  assign access   = bus.mem_read | bus.mem_write;
  assign widx     = bus.addr[ADDR_WIDTH+1:2];

  assign rd_ok    = bus.mem_read  & ~misal & mapped;
  assign wr_ok    = bus.mem_write & ~misal & mapped;

  assign stat_set = {access & ~mapped, access & misal};
  assign stat_clr = (wr_ok & hit_stat) ? bus.write_data[1:0] : 2'b00;

  always_comb begin
    bus.read_data = 32'h0;
    if (rd_ok) begin
      if (hit_ram)       bus.read_data = ram[widx];
      else if (hit_gpio) bus.read_data = {{(32-GPIO_WIDTH){1'b0}}, gpio_out};
      else if (hit_cyc)  bus.read_data = cyc_cnt;
      else if (hit_stat) bus.read_data = {30'h0, status};
    end
  end

  // RAM has no reset; reset only suppresses a concurrent store.
  always_ff @(posedge clk) begin
    if (!reset && wr_ok && hit_ram)
      ram[widx] <= bus.write_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out <= '0;
      cyc_cnt  <= 32'h0;
      status   <= 2'b00;
    end else begin
      if (wr_ok && hit_gpio)
        gpio_out <= bus.write_data[GPIO_WIDTH-1:0];
      if (wr_ok && hit_cyc)
        cyc_cnt <= 32'h0;
      else
        cyc_cnt <= cyc_cnt + 32'd1;
      status <= (status & ~stat_clr) | stat_set;
    end
  end

  assign err = |status;

endmodule

// File: tb/tb_mips_data_mem.sv
// Directed bench for mips_data_mem: vector table for RAM/MMIO behaviour plus
// hand-written sequences for counter wrap/clear and reset-vs-store.
module tb_mips_data_mem;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] gpio_out;
  logic       err;
  int         n_cmp = 0;
  int         n_bad = 0;

  mips_data_mem_if bus ();

  mips_data_mem #(.ADDR_WIDTH(8), .GPIO_WIDTH(8), .MMIO_BASE(32'hFFFF_0000)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .gpio_out (gpio_out),
    .err      (err)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] GPIO = 32'hFFFF_0000;
  localparam logic [31:0] CYC  = 32'hFFFF_0004;
  localparam logic [31:0] STAT = 32'hFFFF_0008;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;    // read_data in the cycle the request is presented
    logic [7:0]  exp_gpio;  // after the edge
    logic        exp_err;   // after the edge
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bus.mem_read   = rd;
    bus.mem_write  = wr;
    bus.addr       = a;
    bus.write_data = d;
  endtask

  vec_t vecs [$];

  initial begin
    vecs = '{
      '{0, 1, 32'h10,  32'hDEAD_BEEF, 32'h0,         8'h00, 0},
      '{1, 0, 32'h10,  32'h0,         32'hDEAD_BEEF, 8'h00, 0},
      '{0, 0, 32'h10,  32'h0,         32'h0,         8'h00, 0},
      '{0, 1, 32'h20,  32'h1111_1111, 32'h0,         8'h00, 0},
      '{1, 1, 32'h20,  32'h2222_2222, 32'h1111_1111, 8'h00, 0},
      '{1, 0, 32'h20,  32'h0,         32'h2222_2222, 8'h00, 0},
      '{0, 1, 32'h13,  32'hCAFE_F00D, 32'h0,         8'h00, 1},
      '{1, 0, 32'h10,  32'h0,         32'hDEAD_BEEF, 8'h00, 1},
      '{1, 0, STAT,    32'h0,         32'h1,         8'h00, 1},
      '{0, 1, STAT,    32'h1,         32'h0,         8'h00, 0},
      '{1, 0, STAT,    32'h0,         32'h0,         8'h00, 0},
      '{1, 0, 32'h4000,32'h0,         32'h0,         8'h00, 1},
      '{1, 0, STAT,    32'h0,         32'h2,         8'h00, 1},
      '{0, 1, STAT,    32'h1,         32'h0,         8'h00, 1},
      '{1, 0, STAT,    32'h0,         32'h2,         8'h00, 1},
      '{0, 1, STAT,    32'h2,         32'h0,         8'h00, 0},
      '{0, 1, 32'h4000,32'h5,         32'h0,         8'h00, 1},
      '{1, 1, STAT,    32'h3,         32'h2,         8'h00, 0},
      '{0, 1, GPIO,    32'h1234_56A5, 32'h0,         8'hA5, 0},
      '{1, 0, GPIO,    32'h0,         32'h0000_00A5, 8'hA5, 0},
      '{1, 0, 32'hFFFF_000C, 32'h0,   32'h0,         8'hA5, 1},
      '{0, 1, STAT,    32'h3,         32'h0,         8'hA5, 0},
      '{0, 1, 32'h3FC, 32'h0BAD_C0DE, 32'h0,         8'hA5, 0},
      '{1, 0, 32'h3FC, 32'h0,         32'h0BAD_C0DE, 8'hA5, 0},
      '{1, 0, 32'h400, 32'h0,         32'h0,         8'hA5, 1},
      '{0, 1, STAT,    32'h2,         32'h0,         8'hA5, 0},
      '{1, 0, 32'h10,  32'h0,         32'hDEAD_BEEF, 8'hA5, 0}
    };

    reset = 1'b1;
    drive(0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    drive(1, 0, CYC, 32'h0);
    #1;
    check("reset_cyc", bus.read_data, 32'h0);
    check("reset_gpio", {24'h0, gpio_out}, 32'h0);
    check("reset_err", {31'h0, err}, 32'h0);
    drive(1, 0, STAT, 32'h0);
    #1;
    check("reset_stat", bus.read_data, 32'h0);

    // Vector table
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d_rd", i), bus.read_data, vecs[i].exp_rd);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_gpio", i), {24'h0, gpio_out}, {24'h0, vecs[i].exp_gpio});
      check($sformatf("vec%0d_err", i), {31'h0, err}, {31'h0, vecs[i].exp_err});
    end

    // Cycle counter wrap: preload near the top, then count through zero
    @(negedge clk);
    drive(1, 0, CYC, 32'h0);
    force dut.cyc_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.cyc_cnt;
    #1;
    check("cyc_preload", bus.read_data, 32'hFFFF_FFFE);
    @(negedge clk); #1;
    check("cyc_ffffffff", bus.read_data, 32'hFFFF_FFFF);
    @(negedge clk); #1;
    check("cyc_wrap0", bus.read_data, 32'h0);
    @(negedge clk); #1;
    check("cyc_wrap1", bus.read_data, 32'h1);
    // Write clears, overriding that edge's increment
    drive(0, 1, CYC, 32'h5555_5555);
    @(negedge clk);
    drive(1, 0, CYC, 32'h0);
    #1;
    check("cyc_clear0", bus.read_data, 32'h0);
    @(negedge clk); #1;
    check("cyc_clear1", bus.read_data, 32'h1);

    // Reset with a concurrent RAM store: store dropped, MMIO state cleared
    drive(0, 1, 32'h40, 32'h1234_5678);
    @(negedge clk);
    drive(0, 1, STAT, 32'h0);
    drive(1, 0, 32'hFFFF_0010, 32'h0);
    @(negedge clk);
    check("pre_reset_err", {31'h0, err}, 32'h1);
    check("pre_reset_gpio", {24'h0, gpio_out}, 32'h0000_00A5);
    reset = 1'b1;
    drive(0, 1, 32'h40, 32'hFFFF_FFFF);
    @(negedge clk);
    reset = 1'b0;
    drive(1, 0, 32'h40, 32'h0);
    #1;
    check("rst_ram_kept", bus.read_data, 32'h1234_5678);
    check("rst_gpio", {24'h0, gpio_out}, 32'h0);
    check("rst_err", {31'h0, err}, 32'h0);
    drive(1, 0, CYC, 32'h0);
    #1;
    check("rst_cyc", bus.read_data, 32'h0);
    drive(1, 0, 32'h10, 32'h0);
    #1;
    check("rst_ram_old", bus.read_data, 32'hDEAD_BEEF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
